// File: rtl/output_logic.sv
// Output-side packet drain: one independent FSM per channel pops a committed packet
// from its FIFO byte by byte and forwards header, payload and optional CRC on req/ack.
module output_logic #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_SIZE  = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2:0]              fifo_pkt_avail,
  input  logic [2:0]              fifo_empty,
  input  logic [3*DATA_WIDTH-1:0] fifo_data_out,
  output logic [2:0]              fifo_pop,
  input  logic                    crc_en,
  output logic [3*DATA_WIDTH-1:0] data_out,
  output logic [2:0]              data_out_req,
  input  logic [2:0]              data_out_ack,
  output logic [2:0]              busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SEND  = 3'd3,
    ST_WAIT  = 3'd4
  } state_e;

  // Handshake: a byte transfers on a rising edge where req=1 and ack=1; until then
  // req stays high and data is held stable. ack while req=0 is ignored.
  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  req_q, req_d;
    logic [DATA_SIZE:0]    rem_q, rem_d;
    logic                  hdr_q, hdr_d;
    logic                  crc_l_q, crc_l_d;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        data_q  <= '0;
        req_q   <= 1'b0;
        rem_q   <= '0;
        hdr_q   <= 1'b0;
        crc_l_q <= 1'b0;
      end else begin
        state_q <= state_d;
        data_q  <= data_d;
        req_q   <= req_d;
        rem_q   <= rem_d;
        hdr_q   <= hdr_d;
        crc_l_q <= crc_l_d;
      end
    end

    always_comb begin
      state_d = state_q;
      data_d  = data_q;
      rem_d   = rem_q;
      hdr_d   = hdr_q;
      crc_l_d = crc_l_q;
      case (state_q)
        ST_IDLE: begin
          if (fifo_pkt_avail[ch]) begin
            state_d = ST_FETCH;
            crc_l_d = crc_en;
            hdr_d   = 1'b1;
          end
        end
        ST_FETCH: state_d = ST_LOAD;
        ST_LOAD: begin
          data_d  = fifo_data_out[ch*DATA_WIDTH +: DATA_WIDTH];
          state_d = ST_SEND;
          // The first byte of a packet is its header: remaining = length (+ CRC byte).
          if (hdr_q) begin
            rem_d = {1'b0, fifo_data_out[ch*DATA_WIDTH +: DATA_SIZE]}
                  + {{DATA_SIZE{1'b0}}, crc_l_q};
            hdr_d = 1'b0;
          end
        end
        ST_SEND: begin
          if (data_out_ack[ch]) begin
            if (rem_q == '0) begin
              state_d = ST_IDLE;
            end else begin
              rem_d   = rem_q - 1'b1;
              state_d = fifo_empty[ch] ? ST_WAIT : ST_FETCH;
            end
          end
        end
        ST_WAIT: begin
          if (!fifo_empty[ch]) state_d = ST_FETCH;
        end
        default: state_d = ST_IDLE;
      endcase
      req_d = (state_d == ST_SEND);
    end

    assign fifo_pop[ch]                            = (state_q == ST_FETCH);
    assign busy[ch]                                = (state_q != ST_IDLE);
    assign data_out_req[ch]                        = req_q;
    assign data_out[ch*DATA_WIDTH +: DATA_WIDTH]   = data_q;
  end

endmodule

// File: tb/tb_output_logic.sv
// Bench for output_logic: FIFO models feed the three channels, a monitor scoreboards
// every transferred byte against the packet stream, and scenario tasks check timing.
`timescale 1ns/1ps
module tb_output_logic;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    fifo_pkt_avail = '0;
  logic [2:0]    fifo_empty = 3'b111;
  logic [3*DW-1:0] fifo_data_out = '0;
  logic [2:0]    fifo_pop;
  logic          crc_en;
  logic [3*DW-1:0] data_out;
  logic [2:0]    data_out_req;
  logic [2:0]    data_out_ack;
  logic [2:0]    busy;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fq0[$], fq1[$], fq2[$];
  logic [DW-1:0] exp_q0[$], exp_q1[$], exp_q2[$];
  int            xfer_cnt[3];
  logic          pend[3];
  logic [DW-1:0] pend_data[3];
  logic          rand_mode = 1'b0;
  logic [DW-1:0] mon_d, mon_e;

  always #5 clk = ~clk;

  output_logic #(.DATA_WIDTH(8), .DATA_SIZE(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .fifo_pkt_avail(fifo_pkt_avail), .fifo_empty(fifo_empty),
    .fifo_data_out(fifo_data_out), .fifo_pop(fifo_pop),
    .crc_en(crc_en), .data_out(data_out), .data_out_req(data_out_req),
    .data_out_ack(data_out_ack), .busy(busy)
  );

  // ---------------- queue helpers ----------------
  function automatic int fq_size(input int ch);
    case (ch)
      0: return fq0.size();
      1: return fq1.size();
      default: return fq2.size();
    endcase
  endfunction

  function automatic logic [DW-1:0] fq_pop(input int ch);
    case (ch)
      0: return fq0.pop_front();
      1: return fq1.pop_front();
      default: return fq2.pop_front();
    endcase
  endfunction

  function automatic int exp_size(input int ch);
    case (ch)
      0: return exp_q0.size();
      1: return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [DW-1:0] exp_pop(input int ch);
    case (ch)
      0: return exp_q0.pop_front();
      1: return exp_q1.pop_front();
      default: return exp_q2.pop_front();
    endcase
  endfunction

  function automatic void q_push(input int ch, input logic [DW-1:0] b);
    case (ch)
      0: begin fq0.push_back(b); exp_q0.push_back(b); end
      1: begin fq1.push_back(b); exp_q1.push_back(b); end
      default: begin fq2.push_back(b); exp_q2.push_back(b); end
    endcase
  endfunction

  function automatic void ch_clear(input int ch);
    case (ch)
      0: begin fq0.delete(); exp_q0.delete(); end
      1: begin fq1.delete(); exp_q1.delete(); end
      default: begin fq2.delete(); exp_q2.delete(); end
    endcase
  endfunction

  // Packet = header (len in low 6 bits, random top bits), len payload bytes, optional CRC.
  task automatic push_pkt(input int ch, input int len, input bit crc);
    logic [DW-1:0] hdr;
    hdr = 8'($urandom);
    hdr[5:0] = 6'(len);
    q_push(ch, hdr);
    for (int k = 0; k < len; k++) q_push(ch, 8'($urandom));
    if (crc) q_push(ch, 8'($urandom));
  endtask

  // ---------------- FIFO model (negedge) ----------------
  always @(negedge clk) begin
    if (rand_mode) begin
      fifo_pkt_avail = 3'($urandom);
      fifo_empty     = 3'($urandom);
      fifo_data_out  = 24'($urandom);
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (fifo_pop[i] === 1'b1 && rst_n) begin
          checks++;
          if (fq_size(i) == 0) begin
            errors++;
            $display("FAIL fifo_underflow ch%0d: pop=1 with empty fifo, required pop=0", i);
          end else begin
            fifo_data_out[i*DW +: DW] = fq_pop(i);
          end
        end
        fifo_empty[i]     = (fq_size(i) == 0);
        fifo_pkt_avail[i] = (fq_size(i) != 0);
      end
    end
  end

  // ---------------- output monitor / scoreboard (negedge + 3) ----------------
  always begin
    @(negedge clk);
    #3;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        pend[i] = 1'b0;
      end else begin
        mon_d = data_out[i*DW +: DW];
        if (pend[i]) begin
          checks++;
          if (data_out_req[i] !== 1'b1 || mon_d !== pend_data[i]) begin
            errors++;
            $display("FAIL hold_stable ch%0d: req=%b data=%02h, required req=1 data=%02h",
                     i, data_out_req[i], mon_d, pend_data[i]);
          end
        end
        if (data_out_req[i] === 1'b1 && data_out_ack[i] === 1'b1) begin
          checks++;
          xfer_cnt[i]++;
          if (exp_size(i) == 0) begin
            errors++;
            $display("FAIL extra_byte ch%0d: got %02h, required no transfer", i, mon_d);
          end else begin
            mon_e = exp_pop(i);
            if (mon_d !== mon_e) begin
              errors++;
              $display("FAIL byte ch%0d: got %02h, required %02h", i, mon_d, mon_e);
            end
          end
          pend[i] = 1'b0;
        end else begin
          pend[i]      = (data_out_req[i] === 1'b1);
          pend_data[i] = mon_d;
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic next_cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic run_until_idle(input int budget, input bit rand_ack, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (rand_ack) data_out_ack = 3'($urandom);
      next_cyc();
      if (busy === 3'b000 && fq0.size() == 0 && fq1.size() == 0 && fq2.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    rand_mode = 1'b1;
    repeat (2) begin
      data_out_ack = 3'($urandom);
      crc_en = 1'($urandom);
      next_cyc();
    end
    checks++;
    if ({data_out, data_out_req, fifo_pop, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: data=%06h req=%b pop=%b busy=%b, required all 0",
               data_out, data_out_req, fifo_pop, busy);
    end
    rand_mode = 1'b0;
    data_out_ack = '0;
    crc_en = 1'b0;
    next_cyc();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      next_cyc();
      checks++;
      if ({data_out_req, fifo_pop, busy} !== '0) begin
        errors++;
        $display("FAIL post_reset_idle: req=%b pop=%b busy=%b, required 0", data_out_req, fifo_pop, busy);
      end
    end
  endtask

  task automatic test_ch0_timing();
    logic [11:0] pop_m, req_m, busy_m, pop_e, req_e, busy_e;
    int x0, n;
    n = 3;
    crc_en = 1'b0;
    data_out_ack = 3'b001;
    x0 = xfer_cnt[0];
    q_push(0, 8'h02); q_push(0, 8'hA1); q_push(0, 8'hB2);
    next_cyc();
    pop_e = '0; req_e = '0; busy_e = '0;
    for (int k = 0; k < n; k++) begin
      pop_e[1 + 3*k] = 1'b1;
      req_e[3 + 3*k] = 1'b1;
    end
    for (int c = 1; c <= 3*n; c++) busy_e[c] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      pop_m[c]  = fifo_pop[0];
      req_m[c]  = data_out_req[0];
      busy_m[c] = busy[0];
      if (c < 11) next_cyc();
    end
    checks++;
    if (pop_m !== pop_e) begin
      errors++; $display("FAIL ch0_pop_cycles: got %b, required %b", pop_m, pop_e);
    end
    checks++;
    if (req_m !== req_e) begin
      errors++; $display("FAIL ch0_req_cycles: got %b, required %b", req_m, req_e);
    end
    checks++;
    if (busy_m !== busy_e) begin
      errors++; $display("FAIL ch0_busy_cycles: got %b, required %b", busy_m, busy_e);
    end
    checks++;
    if (data_out[7:0] !== 8'hB2) begin
      errors++; $display("FAIL ch0_data_hold: got %02h, required B2", data_out[7:0]);
    end
    checks++;
    if (xfer_cnt[0] - x0 != n) begin
      errors++; $display("FAIL ch0_byte_count: got %0d, required %0d", xfer_cnt[0] - x0, n);
    end
  endtask

  task automatic test_crc_latch();
    int x1;
    bit ok;
    // crc_en=1 at start then dropped: header 00 still carries a CRC byte.
    // crc_en=0 at start then raised: header 00 is sent alone.
    for (int s = 0; s < 2; s++) begin
      crc_en = (s == 0);
      data_out_ack = 3'b010;
      x1 = xfer_cnt[1];
      q_push(1, 8'h00);
      if (s == 0) q_push(1, 8'hC3);
      next_cyc();
      next_cyc();
      crc_en = (s != 0);
      run_until_idle(200, 1'b0, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL crc_latch_timeout s%0d: busy=%b, required 000", s, busy);
      end
      checks++;
      if (xfer_cnt[1] - x1 != 2 - s) begin
        errors++; $display("FAIL crc_latch_count s%0d: got %0d bytes, required %0d", s, xfer_cnt[1] - x1, 2 - s);
      end
    end
    crc_en = 1'b0;
  endtask

  task automatic test_backpressure();
    bit found, stable, ok;
    int x2;
    crc_en = 1'b0;
    data_out_ack = 3'b000;
    x2 = xfer_cnt[2];
    q_push(2, 8'h01); q_push(2, 8'h5A);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      next_cyc();
      found = (data_out_req[2] === 1'b1);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL ch2_req_timeout: req2=%b, required 1", data_out_req[2]);
    end
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (data_out_req[2] !== 1'b1 || data_out[23:16] !== 8'h01 || fifo_pop[2] !== 1'b0) stable = 1'b0;
      next_cyc();
    end
    checks++;
    if (!stable) begin
      errors++; $display("FAIL ch2_stall: req2=%b data=%02h pop2=%b, required 1/01/0",
                         data_out_req[2], data_out[23:16], fifo_pop[2]);
    end
    data_out_ack = 3'b100;
    next_cyc();
    checks++;
    if (fifo_pop[2] !== 1'b1 || data_out_req[2] !== 1'b0) begin
      errors++; $display("FAIL ch2_resume: pop2=%b req2=%b, required pop2=1 req2=0", fifo_pop[2], data_out_req[2]);
    end
    run_until_idle(200, 1'b0, ok);
    checks++;
    if (!ok || xfer_cnt[2] - x2 != 2) begin
      errors++; $display("FAIL ch2_complete: ok=%0d bytes=%0d, required ok=1 bytes=2", ok, xfer_cnt[2] - x2);
    end
  endtask

  task automatic test_all_channels();
    int x[3];
    bit ok;
    crc_en = 1'b1;
    data_out_ack = 3'b111;
    for (int i = 0; i < 3; i++) begin
      x[i] = xfer_cnt[i];
      push_pkt(i, 63, 1'b1);
    end
    next_cyc();
    next_cyc();
    checks++;
    if (fifo_pop !== 3'b111) begin
      errors++; $display("FAIL all_start_together: pop=%b, required 111", fifo_pop);
    end
    run_until_idle(3000, 1'b1, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL all_timeout: busy=%b, required 000", busy);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (xfer_cnt[i] - x[i] != 65) begin
        errors++; $display("FAIL all_count ch%0d: got %0d bytes, required 65", i, xfer_cnt[i] - x[i]);
      end
    end
    crc_en = 1'b0;
  endtask

  task automatic test_random();
    int x[3], len[3];
    bit crc, ok;
    for (int r = 0; r < 4; r++) begin
      crc = (r == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      crc_en = crc;
      for (int i = 0; i < 3; i++) begin
        len[i] = (r == 0 && i == 0) ? 0 : $urandom_range(0, 63);
        x[i] = xfer_cnt[i];
        push_pkt(i, len[i], crc);
      end
      run_until_idle(3000, 1'b1, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL random_timeout r%0d: busy=%b, required 000", r, busy);
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (xfer_cnt[i] - x[i] != 1 + len[i] + int'(crc) || exp_size(i) != 0) begin
          errors++;
          $display("FAIL random_count r%0d ch%0d: got %0d bytes (%0d left), required %0d",
                   r, i, xfer_cnt[i] - x[i], exp_size(i), 1 + len[i] + int'(crc));
        end
      end
    end
    crc_en = 1'b0;
  endtask

  task automatic test_underflow();
    int x0;
    bit seen, waiting, ok;
    crc_en = 1'b0;
    data_out_ack = 3'b001;
    x0 = xfer_cnt[0];
    q_push(0, 8'h02);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      next_cyc();
      seen = (xfer_cnt[0] > x0);
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL uf_header_timeout: no header transfer, required one");
    end
    waiting = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (busy[0] !== 1'b1 || fifo_pop[0] !== 1'b0 || data_out_req[0] !== 1'b0) waiting = 1'b0;
      next_cyc();
    end
    checks++;
    if (!waiting) begin
      errors++; $display("FAIL uf_wait: busy0=%b pop0=%b req0=%b, required 1/0/0",
                         busy[0], fifo_pop[0], data_out_req[0]);
    end
    // The rest of the packet arrives late; the FSM must pick up where it stopped.
    fq0.push_back(8'h11); exp_q0.push_back(8'h11);
    fq0.push_back(8'h22); exp_q0.push_back(8'h22);
    run_until_idle(200, 1'b0, ok);
    checks++;
    if (!ok || xfer_cnt[0] - x0 != 3) begin
      errors++; $display("FAIL uf_resume: ok=%0d bytes=%0d, required ok=1 bytes=3", ok, xfer_cnt[0] - x0);
    end
  endtask

  task automatic test_reset_mid_packet();
    bit found;
    crc_en = 1'b0;
    data_out_ack = 3'b000;
    push_pkt(1, 5, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      next_cyc();
      found = (data_out_req[1] === 1'b1);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL rst_mid_req_timeout: req1=%b, required 1", data_out_req[1]);
    end
    rst_n = 1'b0;
    ch_clear(1);
    next_cyc();
    checks++;
    if (data_out_req !== 3'b000 || busy !== 3'b000 || data_out !== '0) begin
      errors++; $display("FAIL rst_mid_abort: req=%b busy=%b data=%06h, required all 0",
                         data_out_req, busy, data_out);
    end
    rst_n = 1'b1;
    data_out_ack = 3'b111;
    repeat (3) next_cyc();
    checks++;
    if (busy !== 3'b000 || fifo_pop !== 3'b000) begin
      errors++; $display("FAIL rst_mid_no_replay: busy=%b pop=%b, required 000/000", busy, fifo_pop);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      xfer_cnt[i] = 0;
      pend[i] = 1'b0;
      pend_data[i] = '0;
    end
    test_reset();
    test_ch0_timing();
    test_crc_latch();
    test_backpressure();
    test_all_channels();
    test_random();
    test_underflow();
    test_reset_mid_packet();
    repeat (2) next_cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
